sram_data_ctrl: RTL and testbench

Data-side SRAM responder. It accepts load/store requests issued by the execute stage on the `SRAM_DATA_*` request bus and drives the external asynchronous 32-bit SRAM through a multi-cycle access sequence. It stalls the pipeline until the access completes, then returns read data to the memory stage. It sits between the EX/MEM pipeline register and the board-level data SRAM pins.

---
 rtl/sram_data_ctrl.sv | 92 +++++++++
 tb/tb_sram_data_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_data_ctrl.sv
// sram_data_ctrl: data-side responder driving an async 32-bit SRAM with a counted strobe window.
// Define SRAM_WRITE_RECOVERY_EN to add a RECOV cycle after writes (WE_N rises before CE/addr/data release).
module sram_data_ctrl #(
   parameter int WAIT_CYCLES = 2,
   parameter int RAM_AW      = 20
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              SRAM_DATA_CE_I,
   input  logic              SRAM_DATA_WE_I,
   input  logic [3:0]        SRAM_DATA_BE_I,
   input  logic [31:0]       SRAM_DATA_VADDR_I,
   input  logic [31:0]       SRAM_DATA_WDATA_I,
   output logic [31:0]       SRAM_DATA_RDATA_O,
   output logic              SRAM_DATA_DONE_O,
   output logic              STALL_REQ_O,
   output logic [RAM_AW-1:0] RAM_ADDR_O,
   input  logic [31:0]       RAM_DATA_I,
   output logic [31:0]       RAM_DATA_O,
   output logic              RAM_DATA_OE_O,
   output logic [3:0]        RAM_BE_N_O,
   output logic              RAM_CE_N_O,
   output logic              RAM_OE_N_O,
   output logic              RAM_WE_N_O
);
   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
`ifdef SRAM_WRITE_RECOVERY_EN
      RECOV,
`endif
      DONE
   } state_t;
   state_t     state, next;
   logic [3:0] cnt;
   logic [3:0] be;
   logic       write;
   logic       acc;
   logic       rec;
   logic       start;
   logic       unused;
   assign unused = ^{SRAM_DATA_VADDR_I[31:RAM_AW+2], SRAM_DATA_VADDR_I[1:0]};
   assign acc    = state == ACCESS;
   assign start  = state == IDLE && !SRAM_DATA_CE_I;
`ifdef SRAM_WRITE_RECOVERY_EN
   assign rec    = state == RECOV;
`else
   assign rec    = 1'b0;
`endif
   always_ff @(posedge CLK or negedge RST)
      if (!RST) state <= IDLE;
      else      state <= next;
   always_comb begin
      next = state;
      case (state)
         IDLE:    next = SRAM_DATA_CE_I ? IDLE : ACCESS;
`ifdef SRAM_WRITE_RECOVERY_EN
         ACCESS:  next = cnt != 4'd0 ? ACCESS : write ? RECOV : DONE;
         RECOV:   next = DONE;
`else
         ACCESS:  next = cnt != 4'd0 ? ACCESS : DONE;
`endif
         default: next = IDLE;
      endcase
      // reset gates the stall so a held request cannot stall the pipe while RST is low
      STALL_REQ_O      = RST && (start || acc || rec);
      SRAM_DATA_DONE_O = state == DONE;
      RAM_CE_N_O       = !(acc || rec);
      RAM_OE_N_O       = !(acc && !write);
      RAM_WE_N_O       = !(acc && write);
      RAM_DATA_OE_O    = (acc || rec) && write;
      RAM_BE_N_O       = (acc || rec) ? be : 4'hF;
   end
   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         RAM_ADDR_O        <= '0;
         RAM_DATA_O        <= '0;
         SRAM_DATA_RDATA_O <= '0;
         be                <= 4'hF;
         write             <= 1'b0;
         cnt               <= 4'd0;
      end else if (start) begin
         RAM_ADDR_O <= SRAM_DATA_VADDR_I[RAM_AW+1:2];
         RAM_DATA_O <= SRAM_DATA_WDATA_I;
         be         <= SRAM_DATA_BE_I;
         write      <= !SRAM_DATA_WE_I;
         cnt        <= 4'(WAIT_CYCLES - 1);
      end else if (acc) begin
         cnt <= cnt - 4'd1;
         if (cnt == 4'd0 && !write) SRAM_DATA_RDATA_O <= RAM_DATA_I;
      end
endmodule

// File: tb/tb_sram_data_ctrl.sv
// tb_sram_data_ctrl: directed table, random traffic against a word-array reference,
// mid-access reset and a WAIT_CYCLES sweep (1 and 15) on extra instances.
module tb_sram_data_ctrl;
   localparam int W = 2;
   logic        clk = 0, rst_n = 0;
   logic        ce_n = 1, we_n = 1;
   logic [3:0]  be_n = 4'hF;
   logic [31:0] vaddr = 0, wdata = 0;
   logic [31:0] rdata, ram_din, ram_dout;
   logic        done, stall, ram_oe, ram_ce_n, ram_oe_n, ram_we_n;
   logic [19:0] ram_addr;
   logic [3:0]  ram_be_n;
   logic [1:0][31:0] s_rdata, s_dout;
   logic [1:0][19:0] s_addr;
   logic [1:0][3:0]  s_be_n;
   logic [1:0]       s_done, s_stall, s_oe, s_ce_n, s_oe_n, s_we_n;
   logic [31:0] mem [256];
   logic [31:0] ref_mem [256];
   logic [31:0] last_rd = 0, last_m = 32'hFFFF_FFFF;
   int          pass_n = 0, tot_n = 0;
   always #5 clk = ~clk;
   sram_data_ctrl #(.WAIT_CYCLES(W), .RAM_AW(20)) dut (
      .CLK(clk), .RST(rst_n), .SRAM_DATA_CE_I(ce_n), .SRAM_DATA_WE_I(we_n),
      .SRAM_DATA_BE_I(be_n), .SRAM_DATA_VADDR_I(vaddr), .SRAM_DATA_WDATA_I(wdata),
      .SRAM_DATA_RDATA_O(rdata), .SRAM_DATA_DONE_O(done), .STALL_REQ_O(stall),
      .RAM_ADDR_O(ram_addr), .RAM_DATA_I(ram_din), .RAM_DATA_O(ram_dout),
      .RAM_DATA_OE_O(ram_oe), .RAM_BE_N_O(ram_be_n), .RAM_CE_N_O(ram_ce_n),
      .RAM_OE_N_O(ram_oe_n), .RAM_WE_N_O(ram_we_n));
   for (genvar g = 0; g < 2; g++) begin : g_sweep
      sram_data_ctrl #(.WAIT_CYCLES(g == 0 ? 1 : 15), .RAM_AW(20)) u (
         .CLK(clk), .RST(rst_n), .SRAM_DATA_CE_I(ce_n), .SRAM_DATA_WE_I(we_n),
         .SRAM_DATA_BE_I(be_n), .SRAM_DATA_VADDR_I(vaddr), .SRAM_DATA_WDATA_I(wdata),
         .SRAM_DATA_RDATA_O(s_rdata[g]), .SRAM_DATA_DONE_O(s_done[g]), .STALL_REQ_O(s_stall[g]),
         .RAM_ADDR_O(s_addr[g]), .RAM_DATA_I(32'h0), .RAM_DATA_O(s_dout[g]),
         .RAM_DATA_OE_O(s_oe[g]), .RAM_BE_N_O(s_be_n[g]), .RAM_CE_N_O(s_ce_n[g]),
         .RAM_OE_N_O(s_oe_n[g]), .RAM_WE_N_O(s_we_n[g]));
   end
   function automatic logic [31:0] init_word(int i);
      logic [7:0] b;
      b = 8'(i);
      return i == 'h41 ? 32'hDEAD_BEEF : {b, b ^ 8'h3C, ~b, b + 8'd7};
   endfunction
   function automatic logic [31:0] lane_mask(logic [3:0] b);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) m[8*i +: 8] = b[i] ? 8'h00 : 8'hFF;
      return m;
   endfunction
   // async SRAM model: reads combinational, writes land while CE/WE are low at an edge
   assign ram_din = (!ram_ce_n && !ram_oe_n) ? mem[ram_addr[7:0]] : 32'h0;
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      end else if (!ram_ce_n && !ram_we_n) begin
         for (int i = 0; i < 4; i++)
            if (!ram_be_n[i]) mem[ram_addr[7:0]][8*i +: 8] <= ram_dout[8*i +: 8];
      end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tot_n++;
      if (act === exp) pass_n++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask
   task automatic idle(input int n);
      @(negedge clk);
      ce_n = 1;
      repeat (n - 1) @(negedge clk);
   endtask
   // one transaction from its request cycle through DONE; returns at the DONE-cycle negedge
   task automatic req(input logic w_n, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
      logic        wr;
      int          lat;
      logic [31:0] m, exp;
      wr  = !w_n;
      m   = lane_mask(b);
      lat = W + 1;
`ifdef SRAM_WRITE_RECOVERY_EN
      if (wr) lat++;
`endif
      exp = ref_mem[a[9:2]];
      if (wr) ref_mem[a[9:2]] = (exp & ~m) | (d & m);
      @(negedge clk);
      ce_n = 0; we_n = w_n; be_n = b; vaddr = a; wdata = d;
      #1;
      chk("stall_req_cycle", stall, 1);
      chk("ce_n_req_cycle", ram_ce_n, 1);
      for (int c = 1; c <= lat; c++) begin
         @(negedge clk);
         chk("stall", stall, c < lat);
         chk("done", done, c == lat);
         chk("ce_n", ram_ce_n, c == lat);
         if (c <= W) begin
            chk("we_n", ram_we_n, !wr);
            chk("oe_n", ram_oe_n, wr);
            chk("data_oe", ram_oe, wr);
            chk("be_n", ram_be_n, b);
            chk("addr", ram_addr, a[21:2]);
            if (wr) chk("wdata", ram_dout, d);
         end else if (c < lat) begin
            chk("recov_we_n", ram_we_n, 1);
            chk("recov_data_oe", ram_oe, 1);
            chk("recov_wdata", ram_dout, d);
         end else begin
            chk("done_we_n", ram_we_n, 1);
            chk("done_data_oe", ram_oe, 0);
            chk("done_be_n", ram_be_n, 4'hF);
         end
      end
      if (wr) chk("rdata_held", rdata & last_m, last_rd & last_m);
      else begin
         chk("rdata", rdata & m, exp & m);
         last_rd = exp;
         last_m  = m;
      end
   endtask
   typedef struct {
      logic        we_n;
      logic [3:0]  be_n;
      logic [31:0] vaddr;
      logic [31:0] wdata;
      logic [19:0] exp_addr;
      logic [31:0] exp_rd;
   } vec_t;
   vec_t        tbl [7];
   logic [31:0] w0, w4;
   int          n1, n15, d1, d15;
   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      w0 = init_word(0);
      w4 = init_word(4);
      tbl[0] = '{1'b1, 4'b0000, 32'h8000_0104, 32'h0,         20'h00041, 32'hDEAD_BEEF};
      tbl[1] = '{1'b0, 4'b0111, 32'h0000_0013, 32'h5A5A_5A5A, 20'h00004, 32'h0};
      tbl[2] = '{1'b0, 4'b0000, 32'h0000_0200, 32'h1234_5678, 20'h00080, 32'h0};
      tbl[3] = '{1'b1, 4'b0000, 32'h0000_0200, 32'h0,         20'h00080, 32'h1234_5678};
      tbl[4] = '{1'b1, 4'b0000, 32'h0000_0010, 32'h0,         20'h00004, {8'h5A, w4[23:0]}};
      tbl[5] = '{1'b0, 4'b0011, 32'h0000_0002, 32'hBEEF_BEEF, 20'h00000, 32'h0};
      tbl[6] = '{1'b1, 4'b0000, 32'h0000_0000, 32'h0,         20'h00000, {16'hBEEF, w0[15:0]}};
      #2;
      chk("rst_ce_n", ram_ce_n, 1);
      chk("rst_be_n", ram_be_n, 4'hF);
      chk("rst_stall", stall, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_addr", ram_addr, 0);
      repeat (2) @(negedge clk);
      rst_n = 1;
      idle(2);
      foreach (tbl[i]) begin
         req(tbl[i].we_n, tbl[i].be_n, tbl[i].vaddr, tbl[i].wdata);
         chk("tbl_addr", ram_addr, tbl[i].exp_addr);
         if (tbl[i].we_n) chk("tbl_rdata", rdata, tbl[i].exp_rd);
      end
      idle(2);
      chk("byte_store_word4", mem[4], {8'h5A, w4[23:0]});
      chk("byte_store_word5", mem[5], init_word(5));
      for (int i = 0; i < 40; i++) begin
         req(1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom);
         if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
      end
      idle(2);
      req(1'b0, 4'b0000, 32'h0000_03FC, 32'hCAFE_F00D);
      // mid-write reset: assert inside ACCESS with the request still held
      @(negedge clk);
      ce_n = 0; we_n = 0; be_n = 4'b0000; vaddr = 32'h0000_03F8; wdata = 32'h1111_2222;
      @(negedge clk);
      chk("pre_rst_we_n", ram_we_n, 0);
      rst_n = 0;
      #1;
      chk("arst_we_n", ram_we_n, 1);
      chk("arst_ce_n", ram_ce_n, 1);
      chk("arst_be_n", ram_be_n, 4'hF);
      chk("arst_data_oe", ram_oe, 0);
      chk("arst_stall", stall, 0);
      chk("arst_done", done, 0);
      chk("arst_addr", ram_addr, 0);
      chk("arst_wdata", ram_dout, 0);
      chk("arst_rdata", rdata, 0);
      ce_n = 1;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      last_rd = 0;
      last_m  = 32'hFFFF_FFFF;
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      chk("post_rst_ce_n", ram_ce_n, 1);
      chk("post_rst_stall", stall, 0);
      req(1'b1, 4'b0000, 32'h8000_0104, 32'h0);
      idle(20);
      // sweep: a one-cycle request pulse starts all three instances on the same edge
      ce_n = 0; we_n = 1; be_n = 4'b0000; vaddr = 32'h0;
      n1 = 0; n15 = 0; d1 = 0; d15 = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 1) ce_n = 1;
         #1;
         n1  += int'(!s_ce_n[0]);
         n15 += int'(!s_ce_n[1]);
         d1  += int'(s_done[0]);
         d15 += int'(s_done[1]);
      end
      chk("wait1_access_len", n1, 1);
      chk("wait15_access_len", n15, 15);
      chk("wait1_done_count", d1, 1);
      chk("wait15_done_count", d15, 1);
      $display("%0d/%0d checks passed", pass_n, tot_n);
      $finish;
   end
endmodule
